bcdbin_seq: RTL and testbench
=============================

Name: bcdbin_seq

Overview:
Sequential multi-digit packed-BCD to binary converter. It is the reverse-direction partner of the team's binary-to-BCD converters. Conversion uses reverse double-dabble: one shift-right plus per-digit correction per clock, with a start/busy/done handshake. It sits between BCD entry/display logic and binary arithmetic datapaths.

Parameters:
- DIGITS, 4: number of BCD digits in bcd_in; legal range 1..8.
- BIN_W, 14: binary result width; must be >= ceil(log2(10^DIGITS)); 14 for DIGITS=4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; sampled only when the FSM is in IDLE.
- bcd_in  in  4*DIGITS  packed BCD operand; digit 0 is in bits [3:0]; sampled when start is accepted.
- bin_out  out  BIN_W  binary result; registered; held until the next completion.
- busy  out  1  high while state is CONV.
- done  out  1  one-cycle pulse; bin_out is valid in that cycle.
- err  out  1  invalid-digit flag; valid with done. Tied 0 when BCDBIN_CHECK_EN is undefined.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; bin_out=0, busy=0, done=0, err=0; shift registers cleared. Reset applies from any state; a conversion in progress is aborted with no done pulse.
- States:
  - IDLE: if start=1, capture bcd_in into bcd_sh, clear bin_sh, load iteration counter with BIN_W, go to CONV.
  - CONV: each cycle, shift {bcd_sh, bin_sh} right by 1, then adjust every 4-bit digit of bcd_sh: if digit >= 8, subtract 3.
  - Counter decrements each CONV cycle; when it reaches 0, go to IDLE.
  - On that final edge: bin_out <= post-shift bin_sh, done <= 1.
- Counter width: clog2(BIN_W+1).
- Latency: start accepted at edge 0; done=1 in the cycle after edge BIN_W (14 edges for defaults). Throughput: one result per BIN_W+1 cycles.
- done is high for exactly one cycle.
- start while busy=1 is ignored; it is not queued.
- start in the cycle where done=1 (FSM already in IDLE) is accepted, giving back-to-back conversions.
- bcd_in may change after acceptance without affecting the result.
- All-zero input still takes the full latency.
- Widths: the digit adjust never underflows (operand >= 8). The shift-in bit enters bin_sh MSB; after BIN_W shifts bin_sh holds the exact value. Maximum input 10^DIGITS - 1 fits by the BIN_W rule.
- Any digit > 9 without the check feature: the output is deterministic but unspecified; the bench must not check it.

Optional Feature:
Macro BCDBIN_CHECK_EN.
- Defined:
  - On start acceptance, every digit of bcd_in is compared against 9.
  - If any digit exceeds 9: no conversion is run. The FSM stays IDLE; the next cycle has done=1, err=1, bin_out=0, so latency is 1.
  - Valid input behaves exactly as in the base behaviour, with err=0.
  - err is registered and holds until the next done.
- Undefined: no comparators are built; err is constant 0.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4.
  - State enum {IDLE, CONV}.
  - Function bin_width(digits) returning ceil(log2(10^digits)), used for BIN_W legality checks.
  - Constant ADJ_THRESH=8, ADJ_SUB=3.
- Sub-module bcd_digit_adj: combinational 4-bit in/out (if in >= 8 then in-3, else in). Instantiated DIGITS times by a generate loop. It is the natural single sub-module.

Test Plan:
- Reset, then bcd_in=16'h0000 with start pulse -> done after 14 cycles, bin_out=14'd0, busy high for exactly 14 cycles.
- bcd_in=16'h1234 -> bin_out=14'h04D2 (1234).
- bcd_in=16'h9999 -> bin_out=14'h270F (9999).
- bcd_in=16'h0007, then start held high through the done cycle with bcd_in=16'h0100 -> first done bin_out=7. The second conversion is accepted on the done cycle; the second done comes 15 cycles later with bin_out=100.
- Start 16'h5678, assert rst at cycle 6 -> no done pulse; all outputs 0 next cycle. Then start 16'h0042 -> bin_out=42 after 14 cycles.
- Start pulses during busy are ignored: result matches the first operand.
- With BCDBIN_CHECK_EN: bcd_in=16'h12A4 -> done and err=1 one cycle after start, bin_out=0. Next, 16'h0010 -> err=0, bin_out=10.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state type and width helper for the BCD-to-binary converter
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd8;
  localparam logic [DIGIT_W-1:0] ADJ_SUB    = 4'd3;

  typedef enum logic {
    IDLE,
    CONV
  } state_e;

  // Smallest width that can hold 10^digits - 1, i.e. ceil(log2(10^digits)).
  function automatic int bin_width(input int digits);
    longint p;
    int     w;
    p = 1;
    w = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < digits) p = p * 10;
    end
    for (int b = 0; b < 63; b++) begin
      if ((longint'(1) << b) < p) w = b + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - reverse double-dabble correction for one BCD digit
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);

  assign d_o = (d_i >= ADJ_THRESH) ? (d_i - ADJ_SUB) : d_i;

endmodule

// File: rtl/bcdbin_seq.sv
// rtl/bcdbin_seq.sv - sequential packed-BCD to binary converter, one shift per clock
// Optional BCDBIN_CHECK_EN rejects operands with any digit above 9 (done+err after one cycle).
module bcdbin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DIGIT_W*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]            bin_out,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcdbin_seq: DIGITS out of range 1..8");
  end
  if (BIN_W < bin_width(DIGITS)) begin : g_bad_width
    $error("bcdbin_seq: BIN_W too small for DIGITS");
  end

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_sh_q, bcd_sh_d;
  logic [BIN_W-1:0]   bin_sh_q, bin_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               done_q, done_d;

  logic [SH_W-1:0]    sh_next;
  logic [BCD_W-1:0]   bcd_adj;
  logic               in_bad;

  // The low bit of the BCD field falls into the binary MSB on every shift.
  assign sh_next = {bcd_sh_q, bin_sh_q} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (sh_next[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .d_o (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCDBIN_CHECK_EN
  logic [DIGITS-1:0] dig_bad;
  logic              err_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    assign dig_bad[g] = (bcd_in[g*DIGIT_W +: DIGIT_W] > 4'd9);
  end
  assign in_bad = |dig_bad;

  // A completion raised from IDLE can only be a rejected operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (done_d) begin
      err_q <= (state_q == IDLE);
    end
  end
  assign err = err_q;
`else
  assign in_bad = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bcd_sh_d  = bcd_sh_q;
    bin_sh_d  = bin_sh_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (in_bad) begin
            bin_out_d = '0;
            done_d    = 1'b1;
          end else begin
            bcd_sh_d = bcd_in;
            bin_sh_d = '0;
            cnt_d    = CNT_W'(BIN_W);
            state_d  = CONV;
          end
        end
      end
      CONV: begin
        bcd_sh_d = bcd_adj;
        bin_sh_d = sh_next[BIN_W-1:0];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = IDLE;
          bin_out_d = sh_next[BIN_W-1:0];
          done_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bcd_sh_q  <= '0;
      bin_sh_q  <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_sh_q  <= bcd_sh_d;
      bin_sh_q  <= bin_sh_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      done_q    <= done_d;
    end
  end

  assign bin_out = bin_out_q;
  assign busy    = (state_q == CONV);
  assign done    = done_q;

endmodule

// File: tb/tb_bcdbin_seq.sv
// tb/tb_bcdbin_seq.sv - self-checking bench for bcdbin_seq against an arithmetic reference
// Define BCDBIN_CHECK_EN for both bench and RTL to exercise invalid-digit rejection.
module tb_bcdbin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int LAT    = BIN_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [4*DIGITS-1:0] bcd_in;
  logic [BIN_W-1:0]    bin_out;
  logic                busy;
  logic                done;
  logic                err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcdbin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bcd_value(input logic [4*DIGITS-1:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int n);
    logic [4*DIGITS-1:0] r;
    int m = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // One conversion; optionally pulses start with another operand mid-flight (poke_at >= 0).
  task automatic run_conv(input string tag, input logic [4*DIGITS-1:0] bcd,
                          input int poke_at, input logic [4*DIGITS-1:0] poke_val);
    int edges  = 0;
    int busy_n = 0;
    int exp    = bcd_value(bcd);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = bcd;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'($urandom);
    while (!done && edges < 40) begin
      if (busy) busy_n++;
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = (edges == poke_at);
      if (start) bcd_in = poke_val;
    end
    start = 1'b0;
    check_eq({tag, " done"}, 32'(done), 32'd1);
    check_eq({tag, " latency"}, 32'(edges), 32'(LAT));
    check_eq({tag, " busy cycles"}, 32'(busy_n), 32'(LAT));
    check_eq({tag, " busy at done"}, 32'(busy), 32'd0);
    check_eq({tag, " bin_out"}, 32'(bin_out), 32'(exp));
    check_eq({tag, " err"}, 32'(err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, " done width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int edges;
    int seen;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset bin_out", 32'(bin_out), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset err", 32'(err), 32'd0);
    rst = 1'b0;

    run_conv("zero", 16'h0000, -1, 16'h0000);
    run_conv("1234", 16'h1234, -1, 16'h0000);
    run_conv("9999", 16'h9999, -1, 16'h0000);

    // Back-to-back: start held high, second operand accepted on the done cycle.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0007;
    @(posedge clk);
    @(negedge clk);
    bcd_in = 16'h0100;
    edges  = 0;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq("b2b first latency", 32'(edges), 32'(LAT));
    check_eq("b2b first bin_out", 32'(bin_out), 32'd7);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
    end while (!done && edges < 40);
    check_eq("b2b second latency", 32'(edges), 32'(LAT + 1));
    check_eq("b2b second bin_out", 32'(bin_out), 32'd100);
    @(posedge clk);
    @(negedge clk);

    // Reset mid-conversion aborts with no done pulse.
    start  = 1'b1;
    bcd_in = 16'h5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen = 1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort no done before rst", 32'(seen), 32'd0);
    check_eq("abort done", 32'(done), 32'd0);
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort bin_out", 32'(bin_out), 32'd0);
    seen = 0;
    repeat (16) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check_eq("abort stays idle", 32'(seen), 32'd0);
    run_conv("after abort", 16'h0042, -1, 16'h0000);

    run_conv("start while busy", 16'h1111, 5, 16'h2222);

    for (int k = 0; k < 20; k++) begin
      run_conv($sformatf("rand%0d", k), to_bcd(int'($urandom_range(0, 9999))),
               int'($urandom_range(0, 12)) - 1, to_bcd(int'($urandom_range(0, 9999))));
    end

`ifdef BCDBIN_CHECK_EN
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h12A4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("bad digit done", 32'(done), 32'd1);
    check_eq("bad digit err", 32'(err), 32'd1);
    check_eq("bad digit bin_out", 32'(bin_out), 32'd0);
    check_eq("bad digit busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("bad digit done width", 32'(done), 32'd0);
    check_eq("bad digit err held", 32'(err), 32'd1);
    run_conv("valid after bad", 16'h0010, -1, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
